// File: rtl/tap_scan_regs.sv
`default_nettype none
// ============================================================================
// Module   : tap_scan_regs
// Purpose  : TAP scan datapath: IR plus BYPASS/IDCODE/USER DRs, TDO mux, USER update port
// Revision : 1.0 - initial release
// ============================================================================
module tap_scan_regs #(
  parameter int          IR_WIDTH   = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h1B57_A0E3,
  parameter int          USER_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  TRST,
  input  logic [3:0]            state,
  input  logic                  TDI,
  output logic                  TDO,
  output logic                  tdo_en,
  output logic [IR_WIDTH-1:0]   ir,
  input  logic [USER_WIDTH-1:0] user_dr_in,
  output logic [USER_WIDTH-1:0] user_dr_out,
  output logic                  user_update
);

  localparam logic [3:0] C_ST_TLR        = 4'd0;
  localparam logic [3:0] C_ST_CAPTURE_DR = 4'd3;
  localparam logic [3:0] C_ST_SHIFT_DR   = 4'd4;
  localparam logic [3:0] C_ST_UPDATE_DR  = 4'd8;
  localparam logic [3:0] C_ST_CAPTURE_IR = 4'd10;
  localparam logic [3:0] C_ST_SHIFT_IR   = 4'd11;
  localparam logic [3:0] C_ST_UPDATE_IR  = 4'd15;

  localparam logic [IR_WIDTH-1:0] C_INSTR_IDCODE = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] C_INSTR_USER   = IR_WIDTH'(2);

  logic [IR_WIDTH-1:0]   ir_q;
  logic [IR_WIDTH-1:0]   ir_sh_q;
  logic                  byp_q;
  logic [31:0]           id_sh_q;
  logic [USER_WIDTH-1:0] usr_sh_q;
  logic [USER_WIDTH-1:0] user_dr_out_q;
  logic                  user_update_q;

  logic w_sel_idcode;
  logic w_sel_user;
  logic w_tdo;

  // Anything that is neither IDCODE nor USER (BYPASS included) routes to the 1-bit bypass.
  assign w_sel_idcode = (ir_q == C_INSTR_IDCODE);
  assign w_sel_user   = (ir_q == C_INSTR_USER);

  always_ff @(posedge clk) begin
    if (TRST) begin
      ir_q          <= C_INSTR_IDCODE;
      ir_sh_q       <= '0;
      byp_q         <= 1'b0;
      id_sh_q       <= '0;
      usr_sh_q      <= '0;
      user_dr_out_q <= '0;
      user_update_q <= 1'b0;
    end else begin
      user_update_q <= 1'b0;
      case (state)
        C_ST_TLR:        ir_q    <= C_INSTR_IDCODE;
        C_ST_CAPTURE_IR: ir_sh_q <= IR_WIDTH'(1);
        C_ST_SHIFT_IR:   ir_sh_q <= {TDI, ir_sh_q[IR_WIDTH-1:1]};
        C_ST_UPDATE_IR:  ir_q    <= ir_sh_q;
        C_ST_CAPTURE_DR: begin
          if (w_sel_idcode)    id_sh_q  <= IDCODE_VAL;
          else if (w_sel_user) usr_sh_q <= user_dr_in;
          else                 byp_q    <= 1'b0;
        end
        C_ST_SHIFT_DR: begin
          if (w_sel_idcode)    id_sh_q  <= {TDI, id_sh_q[31:1]};
          else if (w_sel_user) usr_sh_q <= {TDI, usr_sh_q[USER_WIDTH-1:1]};
          else                 byp_q    <= TDI;
        end
        C_ST_UPDATE_DR: begin
          if (w_sel_user) begin
            user_dr_out_q <= usr_sh_q;
            user_update_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_tdo = 1'b0;
    if (state == C_ST_SHIFT_IR) begin
      w_tdo = ir_sh_q[0];
    end else if (state == C_ST_SHIFT_DR) begin
      if (w_sel_idcode)    w_tdo = id_sh_q[0];
      else if (w_sel_user) w_tdo = usr_sh_q[0];
      else                 w_tdo = byp_q;
    end
  end

  assign TDO         = w_tdo;
  assign tdo_en      = (state == C_ST_SHIFT_DR) || (state == C_ST_SHIFT_IR);
  assign ir          = ir_q;
  assign user_dr_out = user_dr_out_q;
  assign user_update = user_update_q;

endmodule
`default_nettype wire

// File: tb/tb_tap_scan_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_tap_scan_regs
// Purpose  : Directed self-checking bench for tap_scan_regs
// Revision : 1.0 - initial release
// ============================================================================
module tb_tap_scan_regs;

  logic       clk = 1'b0;
  logic       TRST = 1'b0;
  logic [3:0] state = 4'd1;
  logic       TDI = 1'b0;
  logic       TDO;
  logic       tdo_en;
  logic [3:0] ir;
  logic [7:0] user_dr_in = 8'h00;
  logic [7:0] user_dr_out;
  logic       user_update;

  int tests_run = 0;
  int tests_failed = 0;

  tap_scan_regs #(.IR_WIDTH(4), .IDCODE_VAL(32'h1B57_A0E3), .USER_WIDTH(8)) dut (
    .clk(clk), .TRST(TRST), .state(state), .TDI(TDI), .TDO(TDO), .tdo_en(tdo_en),
    .ir(ir), .user_dr_in(user_dr_in), .user_dr_out(user_dr_out), .user_update(user_update)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change on the falling edge; the DUT acts on them at the next rising edge.
  task automatic apply(input logic [3:0] st, input logic tdi);
    @(negedge clk);
    state = st;
    TDI   = tdi;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    TRST = 1'b1; state = 4'd0; TDI = 1'b0;
    @(negedge clk);
    TRST = 1'b0;
    #1;
  endtask

  task automatic ir_scan(input logic [3:0] code);
    apply(4'd2, 1'b0); apply(4'd9, 1'b0); apply(4'd10, 1'b0);
    for (int i = 0; i < 4; i++) apply(4'd11, code[i]);
    apply(4'd12, 1'b0); apply(4'd15, 1'b0); apply(4'd1, 1'b0);
  endtask

  // Full DR scan of n bits ending in Update-DR; returns the TDO stream and tdo_en count.
  task automatic dr_scan(input int n, input logic [31:0] tdi_bits,
                         output logic [31:0] tdo_bits, output int en_cnt);
    tdo_bits = '0; en_cnt = 0;
    apply(4'd2, 1'b0); apply(4'd3, 1'b0);
    for (int i = 0; i < n; i++) begin
      apply(4'd4, tdi_bits[i]);
      tdo_bits[i] = TDO;
      if (tdo_en === 1'b1) en_cnt++;
    end
    apply(4'd5, 1'b0); apply(4'd8, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (ir !== 4'b0001) begin tests_failed++; $display("FAIL reset_ir: got %b want 0001", ir); end
    tests_run++;
    if (user_dr_out !== 8'h00 || user_update !== 1'b0) begin
      tests_failed++; $display("FAIL reset_user: got out=%h upd=%b want 00/0", user_dr_out, user_update);
    end
    tests_run++;
    if (TDO !== 1'b0 || tdo_en !== 1'b0) begin
      tests_failed++; $display("FAIL reset_tdo: got TDO=%b en=%b want 0/0", TDO, tdo_en);
    end
  endtask

  task automatic test_idcode();
    logic [31:0] w;
    int en;
    apply(4'd0, 1'b0); apply(4'd1, 1'b0);
    dr_scan(32, 32'h0, w, en);
    apply(4'd1, 1'b0);
    tests_run++;
    if (w !== 32'h1B57_A0E3) begin tests_failed++; $display("FAIL idcode_stream: got %h want 1b57a0e3", w); end
    tests_run++;
    if (en != 32) begin tests_failed++; $display("FAIL idcode_tdo_en: got %0d want 32", en); end
    tests_run++;
    if (user_update !== 1'b0) begin tests_failed++; $display("FAIL idcode_no_update: got %b want 0", user_update); end
  endtask

  task automatic test_ir_bypass();
    logic [3:0] t;
    logic [31:0] w;
    int en;
    apply(4'd9, 1'b0); apply(4'd10, 1'b0);
    for (int i = 0; i < 4; i++) begin
      apply(4'd11, 1'b1);
      t[i] = TDO;
    end
    apply(4'd12, 1'b0);
    apply(4'd15, 1'b0);
    tests_run++;
    if (ir !== 4'b0001) begin tests_failed++; $display("FAIL ir_before_update: got %b want 0001", ir); end
    apply(4'd1, 1'b0);
    tests_run++;
    if (t !== 4'b0001) begin tests_failed++; $display("FAIL ir_capture_tdo: got %b want 0001", t); end
    tests_run++;
    if (ir !== 4'b1111) begin tests_failed++; $display("FAIL ir_bypass: got %b want 1111", ir); end
    dr_scan(3, 32'b101, w, en);
    tests_run++;
    if (w[2:0] !== 3'b010) begin tests_failed++; $display("FAIL bypass_stream: got %b want 010", w[2:0]); end
  endtask

  task automatic test_user_write();
    logic [31:0] w;
    int en;
    ir_scan(4'b0010);
    tests_run++;
    if (ir !== 4'b0010) begin tests_failed++; $display("FAIL user_ir: got %b want 0010", ir); end
    user_dr_in = 8'hA5;
    dr_scan(8, 32'h3C, w, en);
    tests_run++;
    if (user_update !== 1'b0) begin tests_failed++; $display("FAIL user_update_early: got %b want 0", user_update); end
    apply(4'd1, 1'b0);
    tests_run++;
    if (w[7:0] !== 8'hA5) begin tests_failed++; $display("FAIL user_capture_stream: got %h want a5", w[7:0]); end
    tests_run++;
    if (user_dr_out !== 8'h3C || user_update !== 1'b1) begin
      tests_failed++; $display("FAIL user_write: got out=%h upd=%b want 3c/1", user_dr_out, user_update);
    end
    apply(4'd1, 1'b0);
    tests_run++;
    if (user_update !== 1'b0) begin tests_failed++; $display("FAIL user_update_width: got %b want 0", user_update); end
  endtask

  task automatic test_pause();
    logic [7:0] t;
    logic [7:0] tin;
    logic [3:0] pause_seq [4];
    int en_bad;
    pause_seq = '{4'd5, 4'd6, 4'd6, 4'd7};
    tin = 8'hC3;
    user_dr_in = 8'h5A;
    en_bad = 0;
    apply(4'd2, 1'b0); apply(4'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin apply(4'd4, tin[i]); t[i] = TDO; end
    for (int i = 0; i < 4; i++) begin
      apply(pause_seq[i], 1'b1);
      if (tdo_en !== 1'b0 || TDO !== 1'b0) en_bad++;
    end
    for (int i = 3; i < 8; i++) begin apply(4'd4, tin[i]); t[i] = TDO; end
    apply(4'd5, 1'b0); apply(4'd8, 1'b0); apply(4'd1, 1'b0);
    tests_run++;
    if (t !== 8'h5A) begin tests_failed++; $display("FAIL pause_stream: got %h want 5a", t); end
    tests_run++;
    if (en_bad != 0) begin tests_failed++; $display("FAIL pause_tdo_idle: got %0d active cycles want 0", en_bad); end
    tests_run++;
    if (user_dr_out !== 8'hC3 || user_update !== 1'b1) begin
      tests_failed++; $display("FAIL pause_write: got out=%h upd=%b want c3/1", user_dr_out, user_update);
    end
  endtask

  task automatic test_mid_reset();
    logic [3:0] t;
    logic [31:0] w;
    int en;
    apply(4'd2, 1'b0); apply(4'd9, 1'b0); apply(4'd10, 1'b0); apply(4'd11, 1'b1);
    @(negedge clk);
    state = 4'd11; TDI = 1'b1; TRST = 1'b1;
    @(negedge clk);
    TRST = 1'b0; state = 4'd1; TDI = 1'b0;
    #1;
    tests_run++;
    if (ir !== 4'b0001 || user_dr_out !== 8'h00 || user_update !== 1'b0) begin
      tests_failed++; $display("FAIL midreset_regs: got ir=%b out=%h upd=%b want 0001/00/0", ir, user_dr_out, user_update);
    end
    // Shift straight from the held value with TDI=0; a cleared ir_sh emits all zeros.
    for (int i = 0; i < 4; i++) begin apply(4'd11, 1'b0); t[i] = TDO; end
    apply(4'd0, 1'b0); apply(4'd1, 1'b0);
    tests_run++;
    if (t !== 4'b0000) begin tests_failed++; $display("FAIL midreset_ir_sh: got %b want 0000", t); end
    ir_scan(4'b0010);
    user_dr_in = 8'h00;
    dr_scan(8, 32'h3C, w, en);
    apply(4'd1, 1'b0);
    apply(4'd0, 1'b0); apply(4'd1, 1'b0);
    tests_run++;
    if (ir !== 4'b0001 || user_dr_out !== 8'h3C) begin
      tests_failed++; $display("FAIL tlr_keeps_user: got ir=%b out=%h want 0001/3c", ir, user_dr_out);
    end
  endtask

  task automatic test_unknown_instr();
    logic [31:0] w;
    int en;
    ir_scan(4'b0110);
    tests_run++;
    if (ir !== 4'b0110) begin tests_failed++; $display("FAIL unk_ir: got %b want 0110", ir); end
    dr_scan(3, 32'b011, w, en);
    apply(4'd1, 1'b0);
    tests_run++;
    if (w[2:0] !== 3'b110) begin tests_failed++; $display("FAIL unk_bypass_stream: got %b want 110 (bits 2..0)", w[2:0]); end
    tests_run++;
    if (user_dr_out !== 8'h3C || user_update !== 1'b0) begin
      tests_failed++; $display("FAIL unk_user_kept: got out=%h upd=%b want 3c/0", user_dr_out, user_update);
    end
  endtask

  initial begin
    test_reset();
    test_idcode();
    test_ir_bypass();
    test_user_write();
    test_pause();
    test_mid_reset();
    test_unknown_instr();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tap_scan_regs.md
# tap_scan_regs

Scan-register datapath that sits directly downstream of the TAP controller FSM. It consumes the controller's 4-bit state code plus TDI, and holds the instruction register and the BYPASS, IDCODE and USER data registers. It produces TDO and a parallel USER update port toward the core logic. All capture, shift and update actions happen on the rising clk edge at which the corresponding TAP state is present on `state`.

## Interface
- `IR_WIDTH`, 4: instruction register width.
- `IDCODE_VAL`, 32'h1B57_A0E3: IDCODE register capture value; bit 0 must be 1.
- `USER_WIDTH`, 8: USER data register width.
- `clk`  in  1: TCK; single clock for the whole block.
- `TRST`  in  1: synchronous, active-high reset, sampled on the rising clk edge.
- `state`  in  4: current TAP state code, valid for the present cycle. Encoding:
  - 0 Test-Logic-Reset, 1 Run-Test/Idle, 2 Select-DR, 3 Capture-DR
  - 4 Shift-DR, 5 Exit1-DR, 6 Pause-DR, 7 Exit2-DR, 8 Update-DR
  - 9 Select-IR, 10 Capture-IR, 11 Shift-IR, 12 Exit1-IR, 13 Pause-IR, 14 Exit2-IR, 15 Update-IR
- `TDI`  in  1: serial scan input.
- `TDO`  out  1: serial scan output; 0 whenever `tdo_en` = 0.
- `tdo_en`  out  1: high exactly while `state` is Shift-DR (4) or Shift-IR (11).
- `ir`  out  IR_WIDTH: active instruction.
- `user_dr_in`  in  USER_WIDTH: parallel value loaded into the USER shift register at Capture-DR.
- `user_dr_out`  out  USER_WIDTH: USER register parallel output.
- `user_update`  out  1: one-cycle pulse after a USER Update-DR.

## Operation
- **Instructions:**
  - 4'b0001 = IDCODE.
  - 4'b0010 = USER.
  - 4'b1111 = BYPASS.
  - Every other code selects BYPASS as the data register.
- **IR path:**
  - Capture-IR: `ir_sh` <= 4'b0001.
  - Shift-IR: `ir_sh` <= {TDI, `ir_sh`[3:1]}.
  - Update-IR: `ir` <= `ir_sh`.
  - Test-Logic-Reset (state 0): `ir` <= IDCODE. `ir_sh` and `user_dr_out` are unchanged.
- **DR path (acts only on the register selected by `ir`):**
  - Capture-DR:
    - BYPASS: `byp` <= 0.
    - IDCODE: `id_sh` <= IDCODE_VAL.
    - USER: `usr_sh` <= `user_dr_in`.
  - Shift-DR: the selected register shifts right, TDI enters the MSB. BYPASS is 1 bit: `byp` <= TDI.
  - Update-DR with `ir` = USER: `user_dr_out` <= `usr_sh`, and `user_update` pulses in the next cycle.
  - Update-DR with any other `ir`: no parallel effect.
- **TDO (combinational):**
  - Shift-IR: `ir_sh`[0].
  - Shift-DR: LSB of the selected DR (`byp`, `id_sh`[0] or `usr_sh`[0]).
  - All other states: 0.
- Exit1, Exit2, Pause, Select and Run-Test/Idle states hold every register.
- Width rule: shift registers are exactly their parameter width; no sign or extension logic.
- Reset-value mapping: IDCODE is the reset instruction, so IDCODE is readable without an IR scan.

## Timing
- **TRST = 1 at an edge.** Dominates all state actions. Next cycle:
  - `ir` = 4'b0001.
  - `ir_sh`, `byp`, `id_sh`, `usr_sh` = 0.
  - `user_dr_out` = 0.
  - `user_update` = 0.
  - Combinational outputs, while `state` ≠ 4/11: `TDO` = 0, `tdo_en` = 0.
- **Shift timing.** TDO is a function of current registers and `state`. The bit on TDO during the first Shift cycle is bit 0 of the captured value. Each Shift edge advances by one bit.
- **Shift latency.** A TDI bit presented in a Shift-DR cycle reaches TDO after exactly the selected register's width in Shift-DR edges:
  - BYPASS: 1.
  - USER: USER_WIDTH.
  - IDCODE: 32.
- **Update timing.**
  - `ir` changes on the Update-IR edge. The new instruction selects the DR from the next cycle.
  - `user_dr_out` changes on the Update-DR edge.
  - `user_update` is high for exactly the cycle following that edge, then 0.
- **Mid-scan reset.** TRST asserted during Shift aborts the scan: `ir` is not updated from `ir_sh`, and no `user_update` pulse occurs.
- **Mid-scan return to Test-Logic-Reset.** State 0 reached mid-scan via Select-IR resets `ir` only. A partially shifted `usr_sh` is discarded at the next Capture-DR.
- **Repeated Pause/Exit2→Shift loops.** These continue shifting from the held position; no re-capture happens.

## Test plan
1. **IDCODE readout after reset.**
   - Stimulus: TRST pulse, then states 0, 1, 2, 3, then 4 for 32 cycles.
   - Response: TDO sequence LSB-first = 32'h1B57_A0E3, and `tdo_en` = 1 for all 32 cycles.
2. **IR scan to BYPASS.**
   - Stimulus: states 9, 10, then 11×4 with TDI = 1,1,1,1, then 12, 15.
   - Response: TDO during the shifts = 1,0,0,0; after the Update-IR edge `ir` = 4'b1111.
   - Then a DR scan with TDI = 1,0,1 gives TDO = 0,1,0.
3. **USER write/read.**
   - Stimulus: load `ir` = 4'b0010, `user_dr_in` = 8'hA5, DR scan shifting TDI bits of 8'h3C LSB-first, then Update-DR.
   - Response: TDO = bits of 8'hA5 LSB-first; `user_dr_out` = 8'h3C; `user_update` high for exactly one cycle.
4. **Pause in mid-shift.**
   - Stimulus: USER scan with 3 shifts, then states 5, 6, 6, 7, 4, then 5 more shifts.
   - Response: TDO stream is identical to an uninterrupted 8-shift scan; `usr_sh` holds during states 5/6/7.
5. **Reset mid-operation.**
   - Stimulus: TRST asserted during the 2nd Shift-IR cycle.
   - Response: `ir` = 4'b0001; `ir_sh` = 0; `user_dr_out` = 0; no `user_update` pulse.
   - Separately: entering state 0 with `ir` = USER sets `ir` = 4'b0001 while `user_dr_out` keeps 8'h3C.
6. **Unknown instruction.**
   - Stimulus: `ir` = 4'b0110, DR scan with TDI = 1,1,0.
   - Response: 1-bit bypass behaviour, TDO = 0,1,1; `user_dr_out` unchanged.
